// File: rtl/snoop_bus_arbiter_rr.sv
// Round-robin snoop bus arbiter with one dead turnaround cycle between bus owners.
// Define SNOOP_ARB_TIMEOUT_EN to bound each tenure to MAX_HOLD grant cycles.
module snoop_bus_arbiter_rr #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] Bus_req,
    output logic [NUM_REQ-1:0] Bus_grant,
    output logic [1:0]         Grant_id,
    output logic               Bus_busy,
    output logic               Arb_timeout
);

    if (NUM_REQ != 4 || MAX_HOLD < 2) begin : g_param_check
        $error("snoop_bus_arbiter_rr: NUM_REQ must be 4 and MAX_HOLD at least 2");
    end

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    state_e     state;
    logic [1:0] rr_ptr;
    logic [1:0] winner;
    logic       any_req;
    logic       hold_expired;

`ifdef SNOOP_ARB_TIMEOUT_EN
    localparam int unsigned HoldW = $clog2(MAX_HOLD);
    logic [HoldW-1:0] hold_cnt;
    assign hold_expired = (hold_cnt == HoldW'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
    assign Arb_timeout  = 1'b0;
`endif

    assign any_req = |Bus_req;

    // Scan farthest-first so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        winner = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (Bus_req[rr_ptr + 2'(k)]) begin
                winner = rr_ptr + 2'(k);
            end
        end
    end

    // Grant_id doubles as the owner register; it is only meaningful while Bus_busy is set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= StIdle;
            rr_ptr    <= 2'd0;
            Bus_grant <= '0;
            Grant_id  <= 2'd0;
            Bus_busy  <= 1'b0;
`ifdef SNOOP_ARB_TIMEOUT_EN
            hold_cnt    <= '0;
            Arb_timeout <= 1'b0;
`endif
        end else begin
`ifdef SNOOP_ARB_TIMEOUT_EN
            Arb_timeout <= 1'b0;
`endif
            unique case (state)
                StIdle, StTurn: begin
                    if (any_req) begin
                        state     <= StGrant;
                        Bus_grant <= NUM_REQ'(1) << winner;
                        Grant_id  <= winner;
                        Bus_busy  <= 1'b1;
`ifdef SNOOP_ARB_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end else begin
                        state     <= StIdle;
                        Bus_grant <= '0;
                        Bus_busy  <= 1'b0;
                    end
                end
                StGrant: begin
                    if (!Bus_req[Grant_id] || hold_expired) begin
                        state     <= StTurn;
                        Bus_grant <= '0;
                        Bus_busy  <= 1'b0;
                        rr_ptr    <= Grant_id + 2'd1;
`ifdef SNOOP_ARB_TIMEOUT_EN
                        Arb_timeout <= Bus_req[Grant_id];
`endif
                    end
`ifdef SNOOP_ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state     <= StIdle;
                    Bus_grant <= '0;
                    Bus_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snoop_bus_arbiter_rr.sv
// Scoreboard bench for snoop_bus_arbiter_rr: driver queues hand-computed expectations,
// a monitor pops one per clock and compares against the registered outputs.
module tb_snoop_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] Bus_req = 4'b0000;
    logic [3:0] Bus_grant;
    logic [1:0] Grant_id;
    logic       Bus_busy;
    logic       Arb_timeout;

    int checks   = 0;
    int failures = 0;
    int vec_no   = 0;

    typedef struct {
        int         idx;
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];

    snoop_bus_arbiter_rr #(
        .NUM_REQ (4),
        .MAX_HOLD(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Bus_req    (Bus_req),
        .Bus_grant  (Bus_grant),
        .Grant_id   (Grant_id),
        .Bus_busy   (Bus_busy),
        .Arb_timeout(Arb_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input int idx, input logic [3:0] act,
                             input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%b required=%b", name, idx, act, req);
        end
    endtask

    // Drive one request vector at the falling edge; the expectation is for the next rising edge.
    task automatic run_vec(input logic [3:0] req, input logic [3:0] g, input logic [1:0] id,
                           input logic busy, input logic tmo);
        exp_t e;
        @(negedge clk);
        Bus_req = req;
        e.idx   = vec_no;
        e.grant = g;
        e.id    = id;
        e.busy  = busy;
        e.tmo   = tmo;
        exp_q.push_back(e);
        vec_no++;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("grant", e.idx, Bus_grant, e.grant);
                check_val("busy", e.idx, {3'b000, Bus_busy}, {3'b000, e.busy});
                check_val("timeout", e.idx, {3'b000, Arb_timeout}, {3'b000, e.tmo});
                if (e.busy) check_val("grant_id", e.idx, {2'b00, Grant_id}, {2'b00, e.id});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        repeat (3) @(negedge clk);
        check_val("reset_grant", -1, Bus_grant, 4'b0000);
        check_val("reset_busy", -1, {3'b000, Bus_busy}, 4'b0000);
        check_val("reset_id", -1, {2'b00, Grant_id}, 4'b0000);
        check_val("reset_timeout", -1, {3'b000, Arb_timeout}, 4'b0000);
        reset_n = 1'b1;

        // Single requester, held then released (rr_ptr becomes 2).
        run_vec(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        run_vec(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        run_vec(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
        run_vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Round-robin with all requesting: order 2,3,0,1,2, one dead cycle between owners.
        for (int o = 0; o < 4; o++) begin
            logic [1:0] own;
            logic [3:0] oh;
            own = 2'(o + 2);
            oh  = 4'b0001 << own;
            repeat (3) run_vec(4'b1111, oh, own, 1'b1, 1'b0);
            run_vec(4'b1111 & ~oh, 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        run_vec(4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);

        // Owner 2 drops, 3 wins, then 3 drops with req[0] pending: wraps to 0.
        run_vec(4'b1001, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vec(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
        run_vec(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0);
        run_vec(4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vec(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);

        // Release, idle with no request, then previous owner wins alone from rr_ptr=1.
        run_vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vec(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        run_vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        // rr_ptr=1: requester 2 beats 0 despite the lower index.
        run_vec(4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);

`ifdef SNOOP_ARB_TIMEOUT_EN
        repeat (15) run_vec(4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);
        run_vec(4'b0101, 4'b0000, 2'd0, 1'b0, 1'b1);
        run_vec(4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0);
        run_vec(4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vec(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
`else
        // Owner 2 keeps the bus for 40 cycles while others wait.
        repeat (40) run_vec(4'b1101, 4'b0100, 2'd2, 1'b1, 1'b0);
        run_vec(4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vec(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        run_vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vec(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
`endif
        // Owner 2 drops (rr_ptr=3) and 3 takes the bus.
        run_vec(4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vec(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
        drain();

        // Asynchronous reset in the middle of a tenure.
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        Bus_req = 4'b0000;
        #1;
        check_val("async_reset_grant", -2, Bus_grant, 4'b0000);
        check_val("async_reset_busy", -2, {3'b000, Bus_busy}, 4'b0000);
        check_val("async_reset_timeout", -2, {3'b000, Arb_timeout}, 4'b0000);
        @(negedge clk);
        reset_n = 1'b1;

        // rr_ptr restarted at 0, so 1 wins over 3.
        run_vec(4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
        run_vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vec(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
        run_vec(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
